// File: rtl/interrupt_controller_if.sv
// ---------------------------------------------------------------------------
// interrupt_controller_if
// Groups the request/handshake signals between the CPU core side and the
// interrupt controller.
//   i_int_req        external request (asynchronous level)
//   i_imm_in_flight  first word of a two-word instruction in decode/EXM
//   i_branch_taken   EXM taken branch (flush in progress)
//   i_stall          hazard stall
//   i_rti            return-from-interrupt retired in EXM (1-cycle pulse)
//   o_interrupt      1-cycle strobe to fetch/decode
//   o_fetch_stall    hold PC and fetch/decode buffer during injection
//   o_in_service     handler executing
//   o_pending        request latched, not yet acknowledged
// master: core side (drives requests/status, observes controller outputs)
// slave : the interrupt controller
// ---------------------------------------------------------------------------
interface interrupt_controller_if;
    logic i_int_req;
    logic i_imm_in_flight;
    logic i_branch_taken;
    logic i_stall;
    logic i_rti;
    logic o_interrupt;
    logic o_fetch_stall;
    logic o_in_service;
    logic o_pending;

    modport master (
        output i_int_req, i_imm_in_flight, i_branch_taken, i_stall, i_rti,
        input  o_interrupt, o_fetch_stall, o_in_service, o_pending
    );

    modport slave (
        input  i_int_req, i_imm_in_flight, i_branch_taken, i_stall, i_rti,
        output o_interrupt, o_fetch_stall, o_in_service, o_pending
    );
endinterface

// File: rtl/interrupt_controller.sv
// ---------------------------------------------------------------------------
// interrupt_controller
// Synchronizes and edge-detects an external interrupt request, waits for a
// safe point in the pipeline, strobes the interrupt into fetch/decode, stalls
// fetch while decode pushes PC and flags, then tracks the handler until RTI.
//
// Ports:
//   i_clk     core clock, rising edge
//   i_reset   asynchronous, active-high reset
//   ctrl_if   interrupt_controller_if.slave (request, pipeline status,
//             interrupt strobe, fetch stall, in-service, pending)
//
// Parameters:
//   SYNC_STAGES    synchronizer depth on i_int_req (2..4)
//   INJECT_CYCLES  fetch-stall cycles after the strobe (1..7)
//
// All outputs are decoded from registered state only (Moore).
// ---------------------------------------------------------------------------
module interrupt_controller #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned INJECT_CYCLES = 2
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    interrupt_controller_if.slave  ctrl_if
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_INJECT,
        S_SERVICE
    } state_t;

    localparam logic [2:0] CNT_LOAD = 3'(INJECT_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic                   pending_q, pending_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;
    logic                   edge_q;
    logic                   safe_point;

    assign safe_point = !ctrl_if.i_imm_in_flight && !ctrl_if.i_branch_taken
                        && !ctrl_if.i_stall;

    // Synchronizer chain, delayed copy of its last flop, and a registered
    // rising-edge flag that feeds the pending bit one clock later.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ctrl_if.i_int_req};
            dly_q  <= sync_q[SYNC_STAGES-1];
            edge_q <= sync_q[SYNC_STAGES-1] & ~dly_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        case (state_q)
            S_IDLE: begin
                if (pending_q) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (safe_point) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                cnt_d   = CNT_LOAD;
                state_d = S_INJECT;
            end
            S_INJECT: begin
                // Free-running: decode tracks its own injection progress,
                // so a pipeline stall does not hold the counter.
                if (cnt_q == '0) begin
                    state_d = S_SERVICE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_SERVICE: begin
                if (ctrl_if.i_rti) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Pending clears on entry to ACK; a coincident new edge re-sets it
        // so the request is queued for a second service.
        if (state_d == S_ACK) begin
            pending_d = 1'b0;
        end
        if (edge_q) begin
            pending_d = 1'b1;
        end
    end

    assign ctrl_if.o_interrupt   = (state_q == S_ACK);
    assign ctrl_if.o_fetch_stall = (state_q == S_ACK) || (state_q == S_INJECT);
    assign ctrl_if.o_in_service  = (state_q == S_SERVICE);
    assign ctrl_if.o_pending     = pending_q;

endmodule
